stream_demux_1xn: RTL and testbench

- Parametrised, registered 1-to-N stream demultiplexer; next generation of the combinational 1x8 demux.
- Routes one input beat (DATA_W bits) to one of N_OUT output channels selected by `sel`, or to all channels in broadcast mode.
- Uses valid/ready handshakes on both sides, with a one-deep register slot per output.
- Sits between a single producer and N independent consumers. Counts beats dropped because of an illegal select.

---
 rtl/stream_demux_1xn_pkg.sv | 33 +++
 rtl/demux_slot.sv | 54 +++++
 rtl/stream_demux_1xn.sv | 95 +++++++++
 tb/tb_stream_demux_1xn.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_1xn_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents: default widths, clog2 / select-width derivation, and a lane-slice
// macro for addressing one channel inside a flattened N*W bus.

`ifndef STREAM_DEMUX_1XN_LANE
`define STREAM_DEMUX_1XN_LANE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package stream_demux_1xn_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_OUT  = 8;
  localparam int DEF_ERR_W  = 8;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A select port is never narrower than one bit, even for a single channel.
  function automatic int sel_width(input int n_out);
    return (clog2(n_out) > 1) ? clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demux: a single-entry valid/data register.
// Latency: 1 cycle from load to valid.
// Backpressure: holds data while valid && !ready; free when empty or draining.
//
// Ports: clk, rst_n (async active-low); load (write din this edge);
// valid/dout (registered beat); ready (consumer accept); free (slot may load).

module demux_slot
  import stream_demux_1xn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Draining and reloading in the same cycle is allowed, which is what keeps
  // a busy channel running at one beat per cycle.
  assign free = !valid_q || ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with broadcast and illegal-select drop count.
// Latency: 1 cycle from input accept to out_valid.
// Backpressure: in_ready = free slot of sel (AND of all slots in broadcast);
//   illegal selects are always accepted and dropped.
//
// Ports: in_valid/in_ready/in_data/sel/bcast (producer side);
// out_valid/out_ready/out_data (N channels, flattened DATA_W lanes);
// err_cnt (saturating count of dropped illegal-select beats).

module stream_demux_1xn
  import stream_demux_1xn_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int N_OUT  = DEF_N_OUT,
  parameter  int ERR_W  = DEF_ERR_W,
  localparam int SEL_W  = sel_width(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]        err_cnt
);

  // One extra bit so N_OUT itself is representable (e.g. 64 with SEL_W=6).
  localparam logic [SEL_W:0] N_OUT_W = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0] sel_oh;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             sel_legal;
  logic             free_sel;
  logic             accept;
  logic             illegal_acc;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Decode only legal indices; an illegal sel gives an all-zero one-hot, so
  // it can never load a slot.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_oh[k] = (sel == SEL_W'(k));
    end
  end

  assign sel_legal = ({1'b0, sel} < N_OUT_W);
  assign free_sel  = |(free & sel_oh);

  // Independent of in_valid so the producer can look before committing.
  assign in_ready = bcast     ? (&free) :
                    sel_legal ? free_sel : 1'b1;

  assign accept      = in_valid && in_ready;
  assign load        = {N_OUT{accept}} & (bcast ? {N_OUT{1'b1}} : sel_oh);
  assign illegal_acc = accept && !bcast && !sel_legal;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (illegal_acc && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (in_data),
      .valid (out_valid[k]),
      .ready (out_ready[k]),
      .dout  (`STREAM_DEMUX_1XN_LANE(out_data, k, DATA_W)),
      .free  (free[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn: an 8-channel and a 6-channel
// instance, directed scenarios plus randomized traffic against a model.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 8-channel instance
  logic        iv8, ir8, bc8;
  logic [7:0]  id8, ov8, or8, ec8;
  logic [2:0]  sel8;
  logic [63:0] od8;

  // 6-channel instance
  logic        iv6, ir6, bc6;
  logic [7:0]  id6, ec6;
  logic [2:0]  sel6;
  logic [5:0]  ov6, or6;
  logic [47:0] od6;

  int m_err6 = 0;  // expected drop count of the 6-channel instance

  stream_demux_1xn #(.DATA_W(8), .N_OUT(8), .ERR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .sel(sel8), .bcast(bc8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .err_cnt(ec8));

  stream_demux_1xn #(.DATA_W(8), .N_OUT(6), .ERR_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .in_data(id6),
    .sel(sel6), .bcast(bc6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .err_cnt(ec6));

  function automatic logic [7:0] lane8(input int k);
    return od8[k*8 +: 8];
  endfunction

  function automatic logic [7:0] lane6(input int k);
    return od6[k*8 +: 8];
  endfunction

  task automatic test_reset_route();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL rst_ov8 got=%h exp=00", ov8); end
    checks++; if (od8 !== 64'h0) begin failures++; $display("FAIL rst_od8 got=%h exp=0", od8); end
    checks++; if (ec8 !== 8'h00) begin failures++; $display("FAIL rst_ec8 got=%h exp=00", ec8); end
    checks++; if (ov6 !== 6'h00) begin failures++; $display("FAIL rst_ov6 got=%h exp=00", ov6); end
    checks++; if (ec6 !== 8'h00) begin failures++; $display("FAIL rst_ec6 got=%h exp=00", ec6); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    or8 = 8'hFF; iv8 = 1'b1; id8 = 8'hA5; sel8 = 3'd3; bc8 = 1'b0;
    #1;
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL route_ir got=%b exp=1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++; if (ov8 !== 8'h08) begin failures++; $display("FAIL route_ov got=%h exp=08", ov8); end
    checks++; if (lane8(3) !== 8'hA5) begin failures++; $display("FAIL route_dat got=%h exp=a5", lane8(3)); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL route_clr got=%h exp=00", ov8); end
  endtask

  task automatic test_backpressure();
    or8 = 8'hDF; sel8 = 3'd5; bc8 = 1'b0; id8 = 8'h11; iv8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL bp_ir_first got=%b exp=1", ir8); end
    @(posedge clk); #1;
    id8 = 8'h22;
    #1;
    checks++; if (ir8 !== 1'b0) begin failures++; $display("FAIL bp_ir_stall got=%b exp=0", ir8); end
    checks++; if (ov8 !== 8'h20) begin failures++; $display("FAIL bp_ov got=%h exp=20", ov8); end
    checks++; if (lane8(5) !== 8'h11) begin failures++; $display("FAIL bp_dat got=%h exp=11", lane8(5)); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h20) begin failures++; $display("FAIL bp_hold_ov got=%h exp=20", ov8); end
    checks++; if (lane8(5) !== 8'h11) begin failures++; $display("FAIL bp_hold_dat got=%h exp=11", lane8(5)); end
    or8 = 8'hFF;
    #1;
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL bp_ir_release got=%b exp=1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++; if (ov8 !== 8'h20) begin failures++; $display("FAIL bp_next_ov got=%h exp=20", ov8); end
    checks++; if (lane8(5) !== 8'h22) begin failures++; $display("FAIL bp_next_dat got=%h exp=22", lane8(5)); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL bp_drain got=%h exp=00", ov8); end
  endtask

  task automatic test_streaming();
    or8 = 8'hFF; sel8 = 3'd2; bc8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iv8 = 1'b1; id8 = 8'(i);
      #1;
      checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL stream_ir beat=%0d got=%b exp=1", i, ir8); end
      @(posedge clk); #1;
      checks++; if (ov8 !== 8'h04) begin failures++; $display("FAIL stream_ov beat=%0d got=%h exp=04", i, ov8); end
      checks++; if (lane8(2) !== 8'(i)) begin failures++; $display("FAIL stream_dat beat=%0d got=%h exp=%h", i, lane8(2), 8'(i)); end
    end
    iv8 = 1'b0;
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL stream_drain got=%h exp=00", ov8); end
  endtask

  task automatic test_broadcast();
    or8 = 8'h7F; sel8 = 3'd7; bc8 = 1'b0; id8 = 8'h77; iv8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL bc_pre_ir got=%b exp=1", ir8); end
    @(posedge clk); #1;
    bc8 = 1'b1; id8 = 8'h3C;
    #1;
    checks++; if (ir8 !== 1'b0) begin failures++; $display("FAIL bc_blocked_ir got=%b exp=0", ir8); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h80) begin failures++; $display("FAIL bc_noload_ov got=%h exp=80", ov8); end
    checks++; if (lane8(7) !== 8'h77) begin failures++; $display("FAIL bc_hold_dat got=%h exp=77", lane8(7)); end
    or8 = 8'hFF;
    #1;
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL bc_release_ir got=%b exp=1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0; bc8 = 1'b0;
    checks++; if (ov8 !== 8'hFF) begin failures++; $display("FAIL bc_all_ov got=%h exp=ff", ov8); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (lane8(k) !== 8'h3C) begin failures++; $display("FAIL bc_dat ch=%0d got=%h exp=3c", k, lane8(k)); end
    end
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL bc_drain got=%h exp=00", ov8); end
  endtask

  // Random traffic on the 6-channel instance: each channel is modelled as an
  // optional held beat; the producer-side rules decide acceptance.
  task automatic test_random6();
    bit         mv[6];
    logic [7:0] md[6];
    bit         all_free;
    bit         exp_ir;
    for (int k = 0; k < 6; k++) begin mv[k] = 1'b0; md[k] = 8'h00; end
    for (int c = 0; c < 400; c++) begin
      iv6  = ($urandom_range(0, 3) != 0);
      bc6  = ($urandom_range(0, 7) == 0);
      sel6 = 3'($urandom_range(0, 7));
      id6  = 8'($urandom);
      or6  = 6'($urandom) | 6'($urandom);
      #1;
      all_free = 1'b1;
      for (int k = 0; k < 6; k++) if (mv[k] && !or6[k]) all_free = 1'b0;
      if (bc6)            exp_ir = all_free;
      else if (sel6 < 6)  exp_ir = !mv[sel6] || or6[sel6];
      else                exp_ir = 1'b1;
      checks++; if (ir6 !== exp_ir) begin failures++; $display("FAIL rnd_ir cyc=%0d got=%b exp=%b", c, ir6, exp_ir); end
      for (int k = 0; k < 6; k++) begin
        checks++; if (ov6[k] !== mv[k]) begin failures++; $display("FAIL rnd_ov cyc=%0d ch=%0d got=%b exp=%b", c, k, ov6[k], mv[k]); end
        if (mv[k]) begin
          checks++; if (lane6(k) !== md[k]) begin failures++; $display("FAIL rnd_dat cyc=%0d ch=%0d got=%h exp=%h", c, k, lane6(k), md[k]); end
        end
      end
      for (int k = 0; k < 6; k++) if (mv[k] && or6[k]) mv[k] = 1'b0;
      if (iv6 && exp_ir) begin
        if (bc6) begin
          for (int k = 0; k < 6; k++) begin mv[k] = 1'b1; md[k] = id6; end
        end else if (sel6 < 6) begin
          mv[sel6] = 1'b1; md[sel6] = id6;
        end else if (m_err6 < 255) begin
          m_err6++;
        end
      end
      @(posedge clk); #1;
      checks++; if (ec6 !== 8'(m_err6)) begin failures++; $display("FAIL rnd_err cyc=%0d got=%0d exp=%0d", c, ec6, m_err6); end
    end
    iv6 = 1'b0; bc6 = 1'b0; or6 = 6'h3F;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_sat();
    sel6 = 3'd7; bc6 = 1'b0; or6 = 6'h00; iv6 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      id6 = 8'(i);
      #1;
      checks++; if (ir6 !== 1'b1) begin failures++; $display("FAIL ill_ir beat=%0d got=%b exp=1", i, ir6); end
      @(posedge clk); #1;
      if (m_err6 < 255) m_err6++;
      checks++; if (ov6 !== 6'h00) begin failures++; $display("FAIL ill_ov beat=%0d got=%h exp=00", i, ov6); end
      checks++; if (ec6 !== 8'(m_err6)) begin failures++; $display("FAIL ill_err beat=%0d got=%0d exp=%0d", i, ec6, m_err6); end
    end
    checks++; if (ec6 !== 8'd255) begin failures++; $display("FAIL ill_sat got=%0d exp=255", ec6); end
    iv6 = 1'b0; sel6 = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ec6 !== 8'd255) begin failures++; $display("FAIL ill_idle_hold got=%0d exp=255", ec6); end
  endtask

  task automatic test_async_reset();
    or8 = 8'h00; bc8 = 1'b1; id8 = 8'h5A; iv8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL ar_bc_ir got=%b exp=1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0; bc8 = 1'b0;
    checks++; if (ov8 !== 8'hFF) begin failures++; $display("FAIL ar_full_ov got=%h exp=ff", ov8); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL ar_ov got=%h exp=00", ov8); end
    checks++; if (od8 !== 64'h0) begin failures++; $display("FAIL ar_od got=%h exp=0", od8); end
    checks++; if (ec6 !== 8'h00) begin failures++; $display("FAIL ar_ec6 got=%h exp=00", ec6); end
    checks++; if (ov6 !== 6'h00) begin failures++; $display("FAIL ar_ov6 got=%h exp=00", ov6); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov8 !== 8'h00) begin failures++; $display("FAIL ar_post_ov got=%h exp=00", ov8); end
  endtask

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; bc8 = 1'b0; id8 = 8'h00; sel8 = 3'd0; or8 = 8'h00;
    iv6 = 1'b0; bc6 = 1'b0; id6 = 8'h00; sel6 = 3'd0; or6 = 6'h00;
    test_reset_route();
    test_backpressure();
    test_streaming();
    test_broadcast();
    test_random6();
    test_illegal_sat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
